// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the data-side memory responder.
package mem_responder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int IO_PAGE_BIT      = 22;
  localparam int IO_LED_OFFSET    = 0;
  localparam int IO_CYCLES_OFFSET = 1;
  localparam int LED_WIDTH        = 5;

  // Number of 32-bit words held by a RAM of the given size in KiB.
  function automatic int ram_words(input int size_kb);
    return size_kb * 256;
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM with four byte-lane write enables.
// A read and a write on the same edge return the word as it was before the write.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int  MEMORY_SIZE_KB = 8,
  localparam int WORDS          = ram_words(MEMORY_SIZE_KB),
  localparam int AW             = $clog2(WORDS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [AW-1:0] addr,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem_r [WORDS];
  logic [31:0]     rdata_r;

  // Byte-lane writes; the array itself is never reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[addr][i] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register, updated only on a read so the last word is held.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Data-side load/store responder: byte-writable RAM, optional wait states and,
// when MEM_RESPONDER_IO_EN is defined, an IO page with the LED register and a cycle counter.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEMORY_SIZE_KB = 8,
  parameter int WAIT_STATES    = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          mem_addr,
  input  logic                 mem_rstrb,
  input  logic [3:0]           mem_wmask,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_rbusy,
  output logic                 mem_wbusy,
  output logic [LED_WIDTH-1:0] leds
);

  localparam int         AW        = $clog2(ram_words(MEMORY_SIZE_KB));
  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_r, state_next_s;
  logic [3:0]  wcnt_r, wcnt_next_s;
  logic        rbusy_r, rbusy_next_s;
  logic        wbusy_r, wbusy_next_s;
  logic        rdata_load_s;
  logic        is_write_s, accept_s, is_io_s, ram_re_s;
  logic [3:0]  ram_we_s;
  logic [31:0] ram_q_s, rd_word_s, rdata_hold_r;
  logic        unused_addr_s;

  assign is_write_s    = (mem_wmask != 4'b0000);
  assign accept_s      = (state_r == IDLE) && (mem_rstrb || is_write_s);
  assign ram_re_s      = accept_s && mem_rstrb && !is_io_s;
  assign ram_we_s      = (accept_s && !is_io_s) ? mem_wmask : 4'b0000;
  assign unused_addr_s = ^mem_addr;

  mem_responder_ram #(
    .MEMORY_SIZE_KB(MEMORY_SIZE_KB)
  ) u_ram (
    .CLK  (CLK),
    .RESET(RESET),
    .addr (mem_addr[AW+1:2]),
    .re   (ram_re_s),
    .we   (ram_we_s),
    .wdata(mem_wdata),
    .rdata(ram_q_s)
  );

`ifdef MEM_RESPONDER_IO_EN
  localparam int IO_OFF_W = IO_PAGE_BIT - 2;

  logic [IO_OFF_W-1:0]  io_off_s;
  logic [LED_WIDTH-1:0] leds_r;
  logic [31:0]          cycles_r, io_rd_s, io_q_r;
  logic                 rd_io_r;

  assign is_io_s  = mem_addr[IO_PAGE_BIT];
  assign io_off_s = mem_addr[IO_PAGE_BIT-1:2];

  // IO page read decode; unmapped offsets read as zero.
  always_comb begin
    io_rd_s = 32'h0000_0000;
    case (io_off_s)
      IO_OFF_W'(IO_LED_OFFSET):    io_rd_s = {{(32-LED_WIDTH){1'b0}}, leds_r};
      IO_OFF_W'(IO_CYCLES_OFFSET): io_rd_s = cycles_r;
      default:                     io_rd_s = 32'h0000_0000;
    endcase
  end

  // LED register, written through byte lane 0 only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      leds_r <= {LED_WIDTH{1'b0}};
    end else if (accept_s && is_io_s && mem_wmask[0] &&
                 (io_off_s == IO_OFF_W'(IO_LED_OFFSET))) begin
      leds_r <= mem_wdata[LED_WIDTH-1:0];
    end else begin
      leds_r <= leds_r;
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cycles_r <= 32'h0000_0000;
    end else begin
      cycles_r <= cycles_r + 32'd1;
    end
  end

  // Capture the IO read value at the accept edge, alongside the RAM read.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_io_r <= 1'b0;
      io_q_r  <= 32'h0000_0000;
    end else if (accept_s && mem_rstrb) begin
      rd_io_r <= is_io_s;
      io_q_r  <= is_io_s ? io_rd_s : 32'h0000_0000;
    end else begin
      rd_io_r <= rd_io_r;
      io_q_r  <= io_q_r;
    end
  end

  assign rd_word_s = rd_io_r ? io_q_r : ram_q_s;
  assign leds      = leds_r;
`else
  assign is_io_s   = 1'b0;
  assign rd_word_s = ram_q_s;
  assign leds      = {LED_WIDTH{1'b0}};
`endif

  // Next-state logic for the accept/wait sequencer.
  always_comb begin
    state_next_s = state_r;
    wcnt_next_s  = wcnt_r;
    rbusy_next_s = rbusy_r;
    wbusy_next_s = wbusy_r;
    rdata_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && HAS_WAIT) begin
          state_next_s = WAIT;
          wcnt_next_s  = WAIT_LOAD;
          rbusy_next_s = mem_rstrb;
          wbusy_next_s = is_write_s;
        end else begin
          rbusy_next_s = 1'b0;
          wbusy_next_s = 1'b0;
        end
      end
      WAIT: begin
        if (wcnt_r == 4'd0) begin
          state_next_s = IDLE;
          rbusy_next_s = 1'b0;
          wbusy_next_s = 1'b0;
          rdata_load_s = rbusy_r;
        end else begin
          wcnt_next_s = wcnt_r - 4'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        wcnt_next_s  = 4'd0;
        rbusy_next_s = 1'b0;
        wbusy_next_s = 1'b0;
      end
    endcase
  end

  // Sequencer state, busy flags and the delayed read-data register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= IDLE;
      wcnt_r       <= 4'd0;
      rbusy_r      <= 1'b0;
      wbusy_r      <= 1'b0;
      rdata_hold_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_next_s;
      wcnt_r       <= wcnt_next_s;
      rbusy_r      <= rbusy_next_s;
      wbusy_r      <= wbusy_next_s;
      rdata_hold_r <= rdata_load_s ? rd_word_s : rdata_hold_r;
    end
  end

  // With wait states the word is released when busy falls; otherwise straight from the read registers.
  assign mem_rdata = HAS_WAIT ? rdata_hold_r : rd_word_s;
  assign mem_rbusy = rbusy_r;
  assign mem_wbusy = wbusy_r;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance without wait states, one with three.
module tb_mem_responder;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst0, rstrb0, rbusy0, wbusy0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  wmask0;
  logic [4:0]  leds0;

  logic        rst3, rstrb3, rbusy3, wbusy3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  wmask3;
  logic [4:0]  leds3;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp3_q[$];
  int          resp3 = 0;
  logic        busy0_seen = 1'b0;
  logic        acc0_q = 1'b0;
  logic        rst3_q = 1'b0;
  logic [31:0] cyc0_m = 32'd0;

  mem_responder #(.MEMORY_SIZE_KB(8), .WAIT_STATES(0)) u_dut0 (
    .CLK(CLK), .RESET(rst0), .mem_addr(addr0), .mem_rstrb(rstrb0),
    .mem_wmask(wmask0), .mem_wdata(wdata0), .mem_rdata(rdata0),
    .mem_rbusy(rbusy0), .mem_wbusy(wbusy0), .leds(leds0)
  );

  mem_responder #(.MEMORY_SIZE_KB(8), .WAIT_STATES(3)) u_dut3 (
    .CLK(CLK), .RESET(rst3), .mem_addr(addr3), .mem_rstrb(rstrb3),
    .mem_wmask(wmask3), .mem_wdata(wdata3), .mem_rdata(rdata3),
    .mem_rbusy(rbusy3), .mem_wbusy(wbusy3), .leds(leds3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // Reference cycle count: value the IO counter holds at each edge.
  always @(posedge CLK) begin
    cyc0_m <= rst0 ? 32'd0 : cyc0_m + 32'd1;
    acc0_q <= rstrb0 & ~rst0;
    rst3_q <= rst3;
  end

  // Monitor for the zero-wait instance: a response is due the cycle after every read.
  initial begin
    forever @(negedge CLK) begin
      if (acc0_q) begin
        if (exp0_q.size() == 0) fail("w0 unexpected response");
        else check("w0 rdata", rdata0, exp0_q.pop_front());
      end
      if (rbusy0 || wbusy0) busy0_seen = 1'b1;
    end
  end

  // Monitor for the three-wait instance: a response is presented when mem_rbusy falls.
  initial begin
    logic        prev;
    int          blen;
    logic [31:0] e;
    prev = 1'b0;
    blen = 0;
    forever @(negedge CLK) begin
      if (rbusy3) begin
        blen++;
      end else if (prev) begin
        if (exp3_q.size() == 0) begin
          fail("w3 unexpected response");
        end else begin
          e = exp3_q.pop_front();
          if (rst3_q) begin
            check("w3 abort rdata", rdata3, 32'h0);
          end else begin
            check("w3 rdata", rdata3, e);
            check("w3 rbusy cycles", 32'(blen), 32'd3);
            resp3++;
          end
        end
        blen = 0;
      end
      prev = rbusy3;
    end
  end

  task automatic op0(input logic [31:0] a, input logic r, input logic [3:0] m,
                     input logic [31:0] d, input logic [31:0] exp);
    @(posedge CLK); #1;
    addr0 = a; rstrb0 = r; wmask0 = m; wdata0 = d;
    if (r) exp0_q.push_back(exp);
  endtask

  task automatic idle0();
    @(posedge CLK); #1;
    rstrb0 = 1'b0; wmask0 = 4'h0;
  endtask

  task automatic op3(input logic [31:0] a, input logic r, input logic [3:0] m,
                     input logic [31:0] d, input logic [31:0] exp);
    int i;
    int wcyc;
    @(posedge CLK); #1;
    addr3 = a; rstrb3 = r; wmask3 = m; wdata3 = d;
    if (r) exp3_q.push_back(exp);
    @(posedge CLK); #1;
    rstrb3 = 1'b0; wmask3 = 4'h0;
    i = 0;
    wcyc = 0;
    while ((rbusy3 || wbusy3) && i < 20) begin
      if (wbusy3) wcyc++;
      @(posedge CLK); #1;
      i++;
    end
    if (i >= 20) fail("w3 busy timeout");
    if (m != 4'h0) check("w3 wbusy cycles", 32'(wcyc), 32'd3);
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    rst0 = 1'b1; rstrb0 = 1'b0; wmask0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0;
    rst3 = 1'b1; rstrb3 = 1'b0; wmask3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    rst0 = 1'b0; rst3 = 1'b0;
    check("reset rdata0", rdata0, 32'h0);
    check("reset busy0", {30'd0, rbusy0, wbusy0}, 32'h0);
    check("reset leds0", {27'd0, leds0}, 32'h0);
    check("reset rdata3", rdata3, 32'h0);
    check("reset busy3", {30'd0, rbusy3, wbusy3}, 32'h0);

    // Zero wait states: full word, byte lanes, read-before-write, aliasing.
    op0(32'h10,   1'b0, 4'hF, 32'hDEADBEEF, 32'h0);
    op0(32'h10,   1'b1, 4'h0, 32'h0,        32'hDEADBEEF);
    op0(32'h10,   1'b0, 4'h1, 32'h000000AA, 32'h0);
    op0(32'h10,   1'b0, 4'h8, 32'h55000000, 32'h0);
    op0(32'h10,   1'b1, 4'h0, 32'h0,        32'h55ADBEAA);
    op0(32'h20,   1'b0, 4'hF, 32'h0,        32'h0);
    op0(32'h20,   1'b1, 4'hF, 32'h12345678, 32'h0);
    op0(32'h20,   1'b1, 4'h0, 32'h0,        32'h12345678);
    op0(32'h2020, 1'b1, 4'h0, 32'h0,        32'h12345678);
    op0(32'h2024, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0);
    op0(32'h24,   1'b1, 4'h0, 32'h0,        32'hCAFEF00D);
    op0(32'h10,   1'b0, 4'h6, 32'h11223344, 32'h0);
    op0(32'h10,   1'b1, 4'h0, 32'h0,        32'h552233AA);
    idle0();
    repeat (3) idle0();
    check("w0 rdata held", rdata0, 32'h552233AA);

`ifdef MEM_RESPONDER_IO_EN
    op0(32'h0040_0000, 1'b0, 4'h1, 32'hFFFFFF1F, 32'h0);
    idle0();
    check("w0 leds", {27'd0, leds0}, 32'h1F);
    op0(32'h0040_0010, 1'b0, 4'hF, 32'h0BADF00D, 32'h0);
    op0(32'h10,        1'b1, 4'h0, 32'h0, 32'h552233AA);
    op0(32'h0040_0010, 1'b1, 4'h0, 32'h0, 32'h0);
    op0(32'h0040_0000, 1'b1, 4'h0, 32'h0, 32'h0000001F);
    op0(32'h0040_0004, 1'b1, 4'h0, 32'h0, cyc0_m);
    repeat (9) idle0();
    op0(32'h0040_0004, 1'b1, 4'h0, 32'h0, cyc0_m);
    op0(32'h0040_0008, 1'b1, 4'h0, 32'h0, 32'h0);
    idle0();
`else
    op0(32'h0040_0010, 1'b0, 4'hF, 32'h0BADF00D, 32'h0);
    op0(32'h10,        1'b1, 4'h0, 32'h0, 32'h0BADF00D);
    idle0();
    check("w0 leds tied", {27'd0, leds0}, 32'h0);
`endif
    repeat (2) idle0();

    // Three wait states: busy window, dropped request, lanes, read-before-write.
    op3(32'h10, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0);
    @(posedge CLK); #1;
    addr3 = 32'h10; rstrb3 = 1'b1; exp3_q.push_back(32'hDEADBEEF);
    @(posedge CLK); #1;
    rstrb3 = 1'b0;
    @(posedge CLK); #1;
    addr3 = 32'h20; rstrb3 = 1'b1;
    @(posedge CLK); #1;
    rstrb3 = 1'b0;
    i = 0;
    while (rbusy3 && i < 20) begin
      @(posedge CLK); #1;
      i++;
    end
    if (i >= 20) fail("w3 drop timeout");
    repeat (4) @(posedge CLK);
    #1;
    check("w3 responses after drop", 32'(resp3), 32'd1);
    check("w3 rbusy idle after drop", {31'd0, rbusy3}, 32'h0);

    op3(32'h30, 1'b0, 4'hF, 32'h01020304, 32'h0);
    op3(32'h30, 1'b0, 4'h3, 32'hFFFFBEEF, 32'h0);
    op3(32'h30, 1'b1, 4'h0, 32'h0,        32'h0102BEEF);
    op3(32'h30, 1'b1, 4'hF, 32'h77777777, 32'h0102BEEF);
    op3(32'h30, 1'b1, 4'h0, 32'h0,        32'h77777777);

    // Reset in the middle of a wait-state read.
    op3(32'h40, 1'b0, 4'hF, 32'hA5A5A5A5, 32'h0);
    @(posedge CLK); #1;
    addr3 = 32'h40; rstrb3 = 1'b1; exp3_q.push_back(32'hA5A5A5A5);
    @(posedge CLK); #1;
    rstrb3 = 1'b0;
    @(posedge CLK); #1;
    rst3 = 1'b1;
    @(posedge CLK); #1;
    rst3 = 1'b0;
    check("w3 rbusy after reset", {31'd0, rbusy3}, 32'h0);
    check("w3 rdata after reset", rdata3, 32'h0);
    check("w3 leds after reset", {27'd0, leds3}, 32'h0);
    op3(32'h40, 1'b1, 4'h0, 32'h0, 32'hA5A5A5A5);

    repeat (5) @(posedge CLK);
    #1;
    check("w0 queue drained", 32'(exp0_q.size()), 32'd0);
    check("w3 queue drained", 32'(exp3_q.size()), 32'd0);
    check("w0 busy never high", {31'd0, busy0_seen}, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
